axo_uart_bus_bridge: RTL and testbench

AXO_UART_BUS_BRIDGE -- requirements
Module: axo_uart_bus_bridge

---
 rtl/axo_uart_bus_bridge_if.sv | 12 +
 rtl/axo_uart_bus_bridge.sv | 245 ++++++++++++++++++++++++
 tb/tb_axo_uart_bus_bridge.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axo_uart_bus_bridge_if.sv
// Peripheral bus between the UART bridge (initiator) and a single target.
interface axo_peri_bus;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;
  logic        re;
  logic        ready;

  modport initiator (output addr, we, re, wdata, input rdata, ready);
  modport target (input addr, we, re, wdata, output rdata, ready);
endinterface

// File: rtl/axo_uart_bus_bridge.sv
// UART (8N1) to peripheral-bus bridge: 'W' addr[4] data[4] / 'R' addr[4] commands.
// Optional bus timeout enabled by defining AXO_UART_BRIDGE_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a command byte
// ADDR   | collecting 4 address bytes, little-endian
// DATA   | collecting 4 write-data bytes, little-endian
// BUS    | strobe asserted, waiting for ready
// RESP   | transmitting ACK/NAK or 4 read-data bytes
module axo_uart_bus_bridge #(
  parameter int         CLK_DIV  = 16,
  parameter logic [7:0] RESP_ACK = 8'h06,
  parameter logic [7:0] RESP_NAK = 8'h15
) (
  input  logic           clk,
  input  logic           rst_n,
  axo_peri_bus.initiator bus,
  input  logic           rxd,
  output logic           txd,
  output logic           busy
);
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  rx_state_t   rx_st;
  logic        rx_s1, rx_s2, rx_s3;
  logic [15:0] rx_tmr;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_vld, rx_ferr;

  // Synchronisers reset low so the arming period needs real high samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b0;
      rx_s2   <= 1'b0;
      rx_s3   <= 1'b0;
      rx_st   <= RX_ARM;
      rx_tmr  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_s3   <= rx_s2;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_st)
        RX_ARM: begin
          if (!rx_s2) rx_tmr <= '0;
          else if (rx_tmr == DIV_M1) begin
            rx_tmr <= '0;
            rx_st  <= RX_IDLE;
          end else rx_tmr <= rx_tmr + 16'd1;
        end
        RX_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_tmr <= HALF_M1;
            rx_st  <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tmr != 16'd0) rx_tmr <= rx_tmr - 16'd1;
          else if (rx_s2) rx_st <= RX_IDLE;
          else begin
            rx_tmr <= DIV_M1;
            rx_bit <= '0;
            rx_st  <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_tmr != 16'd0) rx_tmr <= rx_tmr - 16'd1;
          else begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_tmr <= DIV_M1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end
        end
        RX_STOP: begin
          if (rx_tmr != 16'd0) rx_tmr <= rx_tmr - 16'd1;
          else begin
            if (rx_s2) rx_vld <= 1'b1;
            else rx_ferr <= 1'b1;
            rx_st <= RX_IDLE;
          end
        end
        default: rx_st <= RX_ARM;
      endcase
    end
  end

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  resp_last;
  logic        is_wr;
  logic [31:0] addr, wdata;
  logic        we, re;
  logic [23:0] resp_word;
  logic [8:0]  tx_sh;
  logic [3:0]  tx_bits;
  logic [15:0] tx_tmr;
`ifdef AXO_UART_BRIDGE_TIMEOUT_EN
  logic [7:0]  to_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      resp_last <= '0;
      is_wr     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      we        <= 1'b0;
      re        <= 1'b0;
      resp_word <= '0;
      tx_sh     <= '1;
      tx_bits   <= '0;
      tx_tmr    <= '0;
      txd       <= 1'b1;
`ifdef AXO_UART_BRIDGE_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_vld) begin
            cnt <= '0;
            if (rx_sh == 8'h57 || rx_sh == 8'h52) begin
              is_wr <= (rx_sh == 8'h57);
              state <= S_ADDR;
            end else begin
              tx_sh     <= {1'b1, RESP_NAK};
              resp_last <= '0;
              txd       <= 1'b0;
              tx_bits   <= 4'd9;
              tx_tmr    <= DIV_M1;
              state     <= S_RESP;
            end
          end
        end
        S_ADDR: begin
          if (rx_ferr) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (rx_vld) begin
            addr[{cnt, 3'b000} +: 8] <= rx_sh;
            if (cnt == 2'd3) begin
              cnt <= '0;
              if (is_wr) state <= S_DATA;
              else begin
                re    <= 1'b1;
                state <= S_BUS;
`ifdef AXO_UART_BRIDGE_TIMEOUT_EN
                to_cnt <= 8'd255;
`endif
              end
            end else cnt <= cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (rx_ferr) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (rx_vld) begin
            wdata[{cnt, 3'b000} +: 8] <= rx_sh;
            if (cnt == 2'd3) begin
              cnt   <= '0;
              we    <= 1'b1;
              state <= S_BUS;
`ifdef AXO_UART_BRIDGE_TIMEOUT_EN
              to_cnt <= 8'd255;
`endif
            end else cnt <= cnt + 2'd1;
          end
        end
        S_BUS: begin
          if (bus.ready) begin
            we      <= 1'b0;
            re      <= 1'b0;
            cnt     <= '0;
            txd     <= 1'b0;
            tx_bits <= 4'd9;
            tx_tmr  <= DIV_M1;
            state   <= S_RESP;
            if (is_wr) begin
              tx_sh     <= {1'b1, RESP_ACK};
              resp_last <= 2'd0;
            end else begin
              tx_sh     <= {1'b1, bus.rdata[7:0]};
              resp_word <= bus.rdata[31:8];
              resp_last <= 2'd3;
            end
          end
`ifdef AXO_UART_BRIDGE_TIMEOUT_EN
          else if (to_cnt == 8'd0) begin
            we        <= 1'b0;
            re        <= 1'b0;
            cnt       <= '0;
            txd       <= 1'b0;
            tx_bits   <= 4'd9;
            tx_tmr    <= DIV_M1;
            tx_sh     <= {1'b1, RESP_NAK};
            resp_last <= 2'd0;
            state     <= S_RESP;
          end else to_cnt <= to_cnt - 8'd1;
`endif
        end
        S_RESP: begin
          // Next start bit follows the stop bit directly, so bytes run back-to-back.
          if (tx_tmr != 16'd0) tx_tmr <= tx_tmr - 16'd1;
          else if (tx_bits != 4'd0) begin
            txd     <= tx_sh[0];
            tx_sh   <= {1'b1, tx_sh[8:1]};
            tx_bits <= tx_bits - 4'd1;
            tx_tmr  <= DIV_M1;
          end else if (cnt == resp_last) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt       <= cnt + 2'd1;
            txd       <= 1'b0;
            tx_sh     <= {1'b1, resp_word[7:0]};
            resp_word <= {8'h00, resp_word[23:8]};
            tx_bits   <= 4'd9;
            tx_tmr    <= DIV_M1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.addr  = addr;
  assign bus.wdata = wdata;
  assign bus.we    = we;
  assign bus.re    = re;
  assign busy      = (state != S_IDLE);
endmodule

// File: tb/tb_axo_uart_bus_bridge.sv
// Directed + randomized bench for axo_uart_bus_bridge with a transaction-level reference model.
module tb_axo_uart_bus_bridge;
  localparam int DIV = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic txd, busy;
  axo_peri_bus bus_i ();

  axo_uart_bus_bridge #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_i), .rxd(rxd), .txd(txd), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: ready rises after rdy_delay wait cycles of an asserted strobe.
  int rdy_delay = 0;
  int rcnt = 0;
  logic [31:0] rd_val = '0;
  assign bus_i.rdata = rd_val;
  always @(negedge clk) begin
    if (bus_i.we || bus_i.re) begin
      bus_i.ready = (rcnt == rdy_delay);
      rcnt++;
    end else begin
      bus_i.ready = 1'b0;
      rcnt = 0;
    end
  end

  int we_pulses = 0, re_pulses = 0, both_hi = 0, strobe_len = 0, unstable = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic prev_stb = 1'b0;
  always @(negedge clk) begin
    logic stb;
    stb = bus_i.we | bus_i.re;
    if (bus_i.we && bus_i.re) both_hi++;
    if (stb && !prev_stb) begin
      if (bus_i.we) we_pulses++;
      else re_pulses++;
      strobe_len = 1;
      cap_addr = bus_i.addr;
      cap_wdata = bus_i.wdata;
    end else if (stb) begin
      strobe_len++;
      if (bus_i.addr !== cap_addr || bus_i.wdata !== cap_wdata) unstable++;
    end
    prev_stb = stb;
  end

  logic [7:0] tx_q[$];
  int tx_t[$];
  int tx_bad = 0;
  always @(negedge clk) begin
    if (rst_n && txd === 1'b0) begin
      int t0;
      logic [7:0] b;
      logic ok;
      t0 = cyc;
      ok = 1'b1;
      b = '0;
      repeat (DIV / 2) @(negedge clk);
      if (txd !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = txd;
      end
      repeat (DIV) @(negedge clk);
      if (txd !== 1'b1) ok = 1'b0;
      if (ok) begin
        tx_q.push_back(b);
        tx_t.push_back(t0);
      end else tx_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_tx(input int n, input string tag);
    int b = 0;
    while (tx_q.size() < n && b < 6000) begin
      @(negedge clk);
      b++;
    end
    chk(tag, tx_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int b = 0;
    while (busy !== 1'b0 && b < 3000) begin
      @(negedge clk);
      b++;
    end
    chk(tag, busy, 1'b0);
  endtask

  // Reference model: a command is a list of bytes; the expected outcome is one
  // bus access and a response derived purely from the command contents.
  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input int dly, input string tag);
    logic [7:0] exp_q[$];
    int we0, re0;
    tx_q.delete();
    tx_t.delete();
    we0 = we_pulses;
    re0 = re_pulses;
    rdy_delay = dly;
    if (!wr) rd_val = d;
    send_byte(wr ? 8'h57 : 8'h52, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'((a >> (8 * i)) & 32'hFF), 1'b1);
    if (wr) for (int i = 0; i < 4; i++) send_byte(8'((d >> (8 * i)) & 32'hFF), 1'b1);
    if (wr) exp_q.push_back(8'h06);
    else for (int i = 0; i < 4; i++) exp_q.push_back(8'((d >> (8 * i)) & 32'hFF));
    wait_tx(exp_q.size(), {tag, "_txcount"});
    wait_idle({tag, "_idle"});
    chk({tag, "_we_pulses"}, we_pulses - we0, wr ? 1 : 0);
    chk({tag, "_re_pulses"}, re_pulses - re0, wr ? 0 : 1);
    chk({tag, "_addr"}, cap_addr, a);
    if (wr) chk({tag, "_wdata"}, cap_wdata, d);
    chk({tag, "_strobe_len"}, strobe_len, dly + 1);
    chk({tag, "_unstable"}, unstable, 0);
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
      chk($sformatf("%s_txbyte%0d", tag, i), tx_q[i], exp_q[i]);
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), tx_t[i] - tx_t[i-1], 10 * DIV);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, re0, n;
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", bus_i.we, 1'b0);
    chk("rst_re", bus_i.re, 1'b0);
    chk("rst_addr", bus_i.addr, 32'h0);
    chk("rst_wdata", bus_i.wdata, 32'h0);
    rst_n = 1'b1;
    repeat (3 * DIV) @(negedge clk);

    run_txn(1'b1, 32'h80000010, 32'hDEADBEEF, 0, "w_basic");
    run_txn(1'b0, 32'h80000004, 32'h12345678, 5, "r_wait5");

    // Unknown command byte
    tx_q.delete();
    we0 = we_pulses;
    re0 = re_pulses;
    send_byte(8'h41, 1'b1);
    wait_tx(1, "nak_txcount");
    if (tx_q.size() > 0) chk("nak_byte", tx_q[0], 8'h15);
    wait_idle("nak_idle");
    chk("nak_no_strobe", (we_pulses - we0) + (re_pulses - re0), 0);
    run_txn(1'b1, $urandom(), $urandom(), $urandom_range(0, 3), "w_after_nak");

    // Framing error on third address byte
    tx_q.delete();
    we0 = we_pulses;
    re0 = re_pulses;
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    chk("ferr_busy", busy, 1'b0);
    chk("ferr_no_strobe", (we_pulses - we0) + (re_pulses - re0), 0);
    chk("ferr_no_tx", tx_q.size(), 0);
    run_txn(1'b0, $urandom(), $urandom(), $urandom_range(0, 3), "r_after_ferr");

    for (int k = 0; k < 6; k++)
      run_txn(1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom_range(0, 4),
              $sformatf("rand%0d", k));

    chk("never_both_strobes", both_hi, 0);
    chk("tx_framing_ok", tx_bad, 0);

    // Reset while a read waits for ready
    rdy_delay = 1000000;
    send_byte(8'h52, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i), 1'b1);
    n = 0;
    while (bus_i.re !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rstbus_re_before", bus_i.re, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbus_re", bus_i.re, 1'b0);
    chk("rstbus_txd", txd, 1'b1);
    chk("rstbus_busy", busy, 1'b0);
    chk("rstbus_addr", bus_i.addr, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rdy_delay = 0;
    repeat (3 * DIV) @(negedge clk);

    // Reset during the start bit of a response byte
    send_byte(8'h57, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'(i * 3), 1'b1);
    n = 0;
    while (txd !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsttx_txd_before", txd, 1'b0);
    repeat (DIV / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rsttx_txd", txd, 1'b1);
    chk("rsttx_busy", busy, 1'b0);
    chk("rsttx_we", bus_i.we, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (14 * DIV) @(negedge clk);
    tx_q.delete();
    tx_t.delete();

    // Ready never arrives
    rdy_delay = 1000000;
    send_byte(8'h52, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 1'b1);
    n = 0;
    while (bus_i.re !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stuck_re_seen", bus_i.re, 1'b1);
    n = 0;
    while (bus_i.re === 1'b1 && n < 1100) begin
      n++;
      @(negedge clk);
    end
`ifdef AXO_UART_BRIDGE_TIMEOUT_EN
    chk("timeout_len", n, 256);
    wait_tx(1, "timeout_txcount");
    if (tx_q.size() > 0) chk("timeout_nak", tx_q[0], 8'h15);
    wait_idle("timeout_idle");
`else
    chk("no_timeout_len", n, 1100);
    chk("no_timeout_busy", busy, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
